// File: rtl/i2c_target.sv
// I2C target with a byte-wide register file behind an auto-incrementing pointer.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
// Write protocol: START, addr+W, pointer byte, data bytes..., STOP.
// Read protocol:  START, addr+R, data bytes (controller ACKs all but the last).
module i2c_target #(
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8
    } state_t;

    // Pin conditioning: two synchronizer stages plus one history stage each.
    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;

    // Protocol state.
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_rw;
    logic              r_acked;
    logic              r_sda_oe;
    logic              r_busy;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_regs [DEPTH];

    // Next-state values produced by the combinational process.
    state_t            w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [7:0]        w_shift_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_rw_nxt;
    logic              w_acked_nxt;
    logic              w_sda_oe_nxt;
    logic              w_busy_nxt;
    logic              w_wr_stb_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [7:0]        w_wr_data_nxt;
    logic              w_reg_we;

    // Bus events derived from the synchronized pins.
    logic              w_scl_rise;
    logic              w_scl_fall;
    logic              w_start;
    logic              w_stop;
    logic [7:0]        w_shift_in;
    logic [7:0]        w_rd_byte;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic              w_byte_done;

    assign w_scl_rise  = r_scl_sync & ~r_scl_hist;
    assign w_scl_fall  = ~r_scl_sync & r_scl_hist;
    assign w_start     = r_scl_sync & r_scl_hist & ~r_sda_sync & r_sda_hist;
    assign w_stop      = r_scl_sync & r_scl_hist & r_sda_sync & ~r_sda_hist;
    assign w_shift_in  = {r_shift[6:0], r_sda_sync};
    assign w_rd_byte   = r_regs[r_ptr];
    assign w_ptr_inc   = r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_byte_done = w_scl_fall && (r_cnt == 4'd8);

    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign dbg_data = r_regs[dbg_addr];

    // Synchronize SCL/SDA; reset to 1 so the idle bus never looks like a START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
        end
    end

    // Protocol state register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'h00;
            r_ptr     <= {ADDR_W{1'b0}};
            r_rw      <= 1'b0;
            r_acked   <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= {ADDR_W{1'b0}};
            r_wr_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_acked   <= w_acked_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Register file: reset to RESET_VAL, written when a data byte is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_reg_we) begin
            r_regs[r_ptr] <= r_shift;
        end else begin
            r_regs[r_ptr] <= r_regs[r_ptr];
        end
    end

    // Next-state logic: START/STOP override, otherwise bit/byte sequencing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_acked_nxt   = r_acked;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_stb_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_reg_we      = 1'b0;

        if (w_start) begin
            // Repeated START keeps the pointer so pointer-write-then-read works.
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else if (w_stop) begin
            // Any partial byte is simply dropped.
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe_nxt = 1'b0;
                end

                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise && (r_cnt != 4'd8)) begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_byte_done) begin
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_sda_oe_nxt = 1'b1;
                                w_rw_nxt     = r_shift[0];
                                w_busy_nxt   = 1'b1;
                                w_state_nxt  = S_ADDR_ACK;
                            end else begin
                                w_state_nxt  = S_IDLE;
                                w_busy_nxt   = 1'b0;
                                w_cnt_nxt    = 4'd0;
                            end
                        end else if (r_state == S_PTR) begin
                            w_ptr_nxt    = r_shift[ADDR_W-1:0];
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = S_PTR_ACK;
                        end else begin
                            w_reg_we      = 1'b1;
                            w_wr_stb_nxt  = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = r_shift;
                            w_ptr_nxt     = w_ptr_inc;
                            w_sda_oe_nxt  = 1'b1;
                            w_state_nxt   = S_WDATA_ACK;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end

                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            w_shift_nxt  = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                            w_cnt_nxt    = 4'd1;
                            w_state_nxt  = S_RDATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 4'd0;
                            w_state_nxt  = S_PTR;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end

                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 4'd0;
                        w_state_nxt  = S_WDATA;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end

                S_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_oe_nxt = 1'b0;
                            w_ptr_nxt    = w_ptr_inc;
                            w_acked_nxt  = 1'b0;
                            w_state_nxt  = S_RDATA_ACK;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                            w_cnt_nxt    = r_cnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end

                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_sync) begin
                            // Controller NACK ends the read.
                            w_sda_oe_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                            w_cnt_nxt    = 4'd0;
                            w_state_nxt  = S_IDLE;
                        end else begin
                            w_acked_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_acked) begin
                        w_shift_nxt  = w_rd_byte;
                        w_sda_oe_nxt = ~w_rd_byte[7];
                        w_cnt_nxt    = 4'd1;
                        w_acked_nxt  = 1'b0;
                        w_state_nxt  = S_RDATA;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end

                default: begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = 4'd0;
                    w_sda_oe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed testbench for i2c_target: a bit-level I2C controller model drives the
// bus; committed writes are checked by a scoreboard monitor on wr_stb.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic [3:0] dbg_addr;
    logic       sda_oe;
    logic       busy;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] dbg_data;
    wire        sda_line = sda_m & ~sda_oe;

    int checks = 0;
    int errors = 0;
    int oe_count = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h39), .ADDR_W(4), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Count cycles in which the target pulls SDA low.
    always @(posedge clk) begin
        if (sda_oe) oe_count <= oe_count + 1;
    end

    // Scoreboard monitor: every wr_stb pulse pops and compares one expected write.
    always @(negedge clk) begin : wr_monitor
        logic [11:0] e;
        if (!rst && wr_stb) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_stb_unexpected: actual addr=%0d data=0x%02h required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_stb_payload: actual addr=%0d data=0x%02h required addr=%0d data=0x%02h",
                             wr_addr, wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp);
        dbg_addr = idx[3:0];
        #1;
        chk($sformatf("dbg_reg%0d", idx), {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(4);
        scl_m = 1'b1; tick(4);
        sda_m = 1'b0; tick(4);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(4);
        scl_m = 1'b1; tick(4);
        sda_m = 1'b1; tick(8);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(4);
        scl_m = 1'b1; tick(8);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(4);
        scl_m = 1'b1; tick(4);
        b = sda_line; tick(4);
        scl_m = 1'b0; tick(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         oe_snap;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 4'd0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        chk("rst_sda_oe",  {31'd0, sda_oe}, 32'd0);
        chk("rst_busy",    {31'd0, busy},   32'd0);
        chk("rst_wr_stb",  {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        for (int i = 0; i < 16; i++) chk_reg(i, 8'h00);

        // Single-byte write: reg 5 <= 0xA5
        i2c_start();
        write_byte(8'h72, ack); chk("w1_addr_ack", {31'd0, ack}, 32'd0);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h05, ack); chk("w1_ptr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back({4'd5, 8'hA5});
        write_byte(8'hA5, ack); chk("w1_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk("w1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk_reg(5, 8'hA5);

        // Burst write wrapping from 15 to 0
        i2c_start();
        write_byte(8'h72, ack); chk("w2_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h0F, ack); chk("w2_ptr_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back({4'd15, 8'h11});
        write_byte(8'h11, ack); chk("w2_d0_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back({4'd0, 8'h22});
        write_byte(8'h22, ack); chk("w2_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk_reg(15, 8'h11);
        chk_reg(0, 8'h22);

        // Preload regs 3/4, then read them back after a repeated START
        i2c_start();
        write_byte(8'h72, ack);
        write_byte(8'h03, ack);
        exp_q.push_back({4'd3, 8'h3C});
        write_byte(8'h3C, ack);
        exp_q.push_back({4'd4, 8'hC3});
        write_byte(8'hC3, ack); chk("pre_d1_ack", {31'd0, ack}, 32'd0);
        i2c_stop();

        i2c_start();
        write_byte(8'h72, ack); chk("r_waddr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h03, ack); chk("r_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h73, ack); chk("r_raddr_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b0);     chk("r_byte0", {24'd0, d}, 32'h3C);
        read_byte(d, 1'b1);     chk("r_byte1", {24'd0, d}, 32'hC3);
        tick(4);
        chk("r_nack_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("r_nack_busy",   {31'd0, busy},   32'd0);
        i2c_stop();

        // Address mismatch: no drive, no busy, then a valid transaction still works
        oe_snap = oe_count;
        i2c_start();
        write_byte(8'h50, ack); chk("mm_ack_is_nack", {31'd0, ack}, 32'd1);
        chk("mm_busy", {31'd0, busy}, 32'd0);
        chk("mm_no_drive", oe_count, oe_snap);
        i2c_stop();
        i2c_start();
        write_byte(8'h72, ack); chk("mm_follow_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h07, ack); chk("mm_follow_ptr_ack", {31'd0, ack}, 32'd0);
        i2c_stop();

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'h72, ack);
        write_byte(8'h02, ack); chk("sm_ptr_ack", {31'd0, ack}, 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        chk("sm_busy", {31'd0, busy}, 32'd0);
        chk_reg(2, 8'h00);

        // Reset while the target is driving read data
        i2c_start();
        write_byte(8'h72, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h73, ack); chk("rr_addr_ack", {31'd0, ack}, 32'd0);
        chk("rr_pre_sda_oe", {31'd0, sda_oe}, 32'd1);
        chk("rr_pre_busy",   {31'd0, busy},   32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rr_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rr_busy",   {31'd0, busy},   32'd0);
        chk("rr_wr_stb", {31'd0, wr_stb}, 32'd0);
        chk_reg(3, 8'h00);
        chk_reg(5, 8'h00);
        chk_reg(15, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        oe_snap = oe_count;
        scl_m = 1'b1; tick(4);
        sda_m = 1'b1; tick(20);
        chk("rr_idle_busy",  {31'd0, busy}, 32'd0);
        chk("rr_idle_drive", oe_count, oe_snap);

        // Pointer is 0 after reset: read reg 0, then a fresh write still works
        i2c_start();
        write_byte(8'h73, ack); chk("rr_read_ack", {31'd0, ack}, 32'd0);
        read_byte(d, 1'b1);     chk("rr_read_reg0", {24'd0, d}, 32'h00);
        i2c_stop();
        i2c_start();
        write_byte(8'h72, ack);
        write_byte(8'h09, ack);
        exp_q.push_back({4'd9, 8'h66});
        write_byte(8'h66, ack); chk("post_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk_reg(9, 8'h66);

        tick(10);
        chk("wr_queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers the configuration transactions issued by the team's I2C controller (`i2c`).
- Holds a byte-wide register file addressed by an auto-incrementing pointer. Doubles as the simulation model of the HDMI transmitter's config port and as an on-chip target for loopback testing.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain through an output-enable (OE) pin.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address that this block matches.
- ADDR_W, 4, width of the register pointer. The register file holds 2**ADDR_W bytes.
- RESET_VAL, 8'h00, reset value of every register byte.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  SCL pin level (asynchronous).
- sda_in  input  1  SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- busy  output  1  high from an address-matched START until STOP or NACK exit.
- wr_stb  output  1  one-cycle pulse when a data byte is committed to the register file.
- wr_addr  output  ADDR_W  register index of the write being strobed.
- wr_data  output  8  data byte of the write being strobed.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  8  combinational read: regs[dbg_addr].

Behaviour:
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - An event (edge, START, STOP) is acted on 3 clk after the pin change.
- Event detection (on synced signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START and STOP take priority over bit processing.
- Bit timing:
  - Bits are sampled on the SCL rising event.
  - sda_oe changes only on the SCL falling event; START/STOP and reset release it immediately.
- State machine states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE:
  - sda_oe=0. Waits for START.
  - START → ADDR with bit count = 0.
- ADDR:
  - Shifts in 8 bits, MSB first.
  - On the 8th SCL fall: if bits[7:1]==DEV_ADDR, assert sda_oe (ACK) and go to ADDR_ACK. Otherwise go to IDLE with no drive (NACK).
- ADDR_ACK:
  - On the SCL fall that ends the ack bit, release sda_oe.
  - R/W=0 → PTR.
  - R/W=1 → RDATA; load the shift register with regs[ptr] and drive its MSB (sda_oe = ~bit) on the same fall.
- PTR:
  - 8 bits shifted in; ptr <= byte[ADDR_W-1:0] (upper bits ignored).
  - ACK the byte, then go to WDATA.
- WDATA:
  - 8 bits shifted in. On the 8th SCL fall: regs[ptr] <= byte, pulse wr_stb for 1 clk with wr_addr=ptr and wr_data=byte, then ptr <= ptr+1 (wraps mod 2**ADDR_W).
  - ACK the byte, then return to WDATA.
- RDATA:
  - Each subsequent SCL fall drives the next bit.
  - After the 8th bit's fall, release SDA, set ptr <= ptr+1 (wrap), and go to RDATA_ACK.
- RDATA_ACK:
  - On the SCL rise, sample SDA. 0 (ACK) → on the next fall, load regs[ptr] and drive its MSB; go to RDATA.
  - 1 (NACK) → IDLE, release SDA.
- Repeated START in any state: release sda_oe, go to ADDR. ptr is retained, so write-pointer-then-read works.
- STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded, with no wr_stb.
- busy: set on ADDR_ACK entry; cleared on IDLE entry.
- Reset (any state, mid-byte included), values after the next clk edge:
  - state=IDLE, sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0.
  - ptr=0, all regs=RESET_VAL, bit count=0.
  - Synchronizer flops reset to 1 (bus idle), so no false START is seen after reset.
- Timing limits:
  - Responds only to a controller that holds SCL high/low for at least 4 clk.
  - Never stretches SCL.

Test Plan:
- Write, single byte: START, 0x72 (addr 0x39, W), 0x05, 0xA5, STOP → ACK on all three bytes; one wr_stb with wr_addr=5, wr_data=0xA5; dbg_addr=5 → dbg_data=0xA5; busy low after STOP.
- Burst write with wrap (ADDR_W=4): pointer 0x0F, data 0x11, 0x22 → regs[15]=0x11, regs[0]=0x22; two wr_stb pulses at addrs 15 then 0.
- Read after repeated START: preload regs[3]=0x3C, regs[4]=0xC3. Write pointer 0x03, repeated START, 0x73, controller ACKs byte 1 and NACKs byte 2 → SDA returns 0x3C then 0xC3; target in IDLE; sda_oe=0 after the NACK.
- Address mismatch: START, 0x50 → SDA never pulled low; no wr_stb; busy stays 0; a following valid transaction is still ACKed.
- STOP mid-byte: write pointer 0x02, send 4 data bits, STOP → no wr_stb; regs[2] unchanged; state IDLE.
- Reset mid-read: assert rst while sda_oe=1 during RDATA → sda_oe=0, busy=0, all regs=RESET_VAL on the next cycle; SCL/SDA held high produce no START.
